// File: rtl/traffic_junction_ctrl.sv
// Two-road junction sequencer with pedestrian WALK phase; main road rests in green.
// state | meaning: NS_G main green | NS_Y main yellow | AR1 clear to side | EW_G side green
//       | EW_Y side yellow | AR2 clear to main | WALK pedestrian crossing | BAD illegal code
module traffic_junction_ctrl #(
  parameter int NS_GREEN_T = 8,
  parameter int EW_GREEN_T = 6,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 5,
  parameter int TW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_color,
  output logic [2:0] ew_color,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR1  = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  localparam logic [TW-1:0] LD_NS_G  = TW'(NS_GREEN_T - 1);
  localparam logic [TW-1:0] LD_EW_G  = TW'(EW_GREEN_T - 1);
  localparam logic [TW-1:0] LD_YEL   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] LD_ALLR  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] LD_WALK  = TW'(WALK_T - 1);

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_ped;

  state_t          w_next;
  logic            w_expired;
  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic            w_enter_walk;

  assign w_expired    = tick && (r_timer == '0);
  assign w_load       = (w_next != r_state);
  assign w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NS_G;
      r_timer <= LD_NS_G;
      r_ped   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_timer <= w_load_val;
      end else if (tick && (r_timer != '0)) begin
        r_timer <= r_timer - TW'(1);
      end
      // Entering WALK serves the request, so the clear beats a same-edge press.
      if (w_enter_walk) begin
        r_ped <= 1'b0;
      end else if (ped_req && (r_state != S_WALK)) begin
        r_ped <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_NS_G: if (w_expired && (ew_car || r_ped)) w_next = S_NS_Y;
      S_NS_Y: if (w_expired) w_next = S_AR1;
      S_AR1:  if (w_expired) w_next = r_ped ? S_WALK : S_EW_G;
      S_WALK: if (w_expired) w_next = ew_car ? S_EW_G : S_AR2;
      S_EW_G: if (w_expired) w_next = S_EW_Y;
      S_EW_Y: if (w_expired) w_next = S_AR2;
      S_AR2:  if (w_expired) w_next = S_NS_G;
      S_BAD:  w_next = S_AR2;
      default: w_next = S_AR2;
    endcase
  end

  always_comb begin
    w_load_val = LD_ALLR;
    case (w_next)
      S_NS_G:        w_load_val = LD_NS_G;
      S_NS_Y, S_EW_Y: w_load_val = LD_YEL;
      S_EW_G:        w_load_val = LD_EW_G;
      S_WALK:        w_load_val = LD_WALK;
      default:       w_load_val = LD_ALLR;
    endcase
  end

  always_comb begin
    ns_color = LAMP_R;
    ew_color = LAMP_R;
    walk     = 1'b0;
    case (r_state)
      S_NS_G: ns_color = LAMP_G;
      S_NS_Y: ns_color = LAMP_Y;
      S_EW_G: ew_color = LAMP_G;
      S_EW_Y: ew_color = LAMP_Y;
      S_WALK: walk     = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = r_ped;
  assign phase       = r_state;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed scenarios plus a random soak, checked every cycle against a phase/tick-count model.
module tb_traffic_junction_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_color, ew_color, phase;
  logic       walk, ped_pending;

  int n_chk = 0;
  int n_err = 0;

  traffic_junction_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .ew_car(ew_car), .ped_req(ped_req),
    .ns_color(ns_color), .ew_color(ew_color), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  // Model: phase index plus ticks seen in the phase, durations from a table.
  int         dur    [7] = '{8, 3, 2, 6, 3, 2, 5};
  logic [2:0] ns_tab [7] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [7] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100};
  int m_ph = 0;
  int m_cnt = 0;
  bit m_ped = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int nph;
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_ped = 0; m_valid = 1;
    end else if (m_valid) begin
      nph = m_ph;
      if (tick && m_cnt >= dur[m_ph] - 1) begin
        case (m_ph)
          0: if (ew_car || m_ped) nph = 1;
          1: nph = 2;
          2: nph = m_ped ? 6 : 3;
          3: nph = 4;
          4: nph = 5;
          5: nph = 0;
          6: nph = ew_car ? 3 : 5;
          default: nph = 5;
        endcase
      end
      if (nph == 6 && m_ph != 6) m_ped = 0;
      else if (ped_req && m_ph != 6) m_ped = 1;
      if (nph != m_ph) m_cnt = 0;
      else if (tick && m_cnt < dur[m_ph]) m_cnt++;
      m_ph = nph;
    end
  end

  always @(negedge clk) begin
    logic [11:0] exp_v, got_v;
    if (m_valid) begin
      exp_v = {m_ph[2:0], ns_tab[m_ph], ew_tab[m_ph], (m_ph == 6), m_ped};
      got_v = {phase, ns_color, ew_color, walk, ped_pending};
      n_chk++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t got{ph,ns,ew,walk,ped}=%h expected=%h", $time, got_v, exp_v);
      end
      n_chk++;
      if (!$onehot(ns_color) || !$onehot(ew_color) ||
          (ns_color != 3'b100 && ew_color != 3'b100)) begin
        n_err++;
        $display("FAIL safety t=%0t ns=%b ew=%b", $time, ns_color, ew_color);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b1; ew_car = 1'b0; ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Idle rest-in-green
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick = 1'b1; ew_car = 1'b0; ped_req = 1'b0;
      if (c == 0) begin
        lit("rst_phase", phase, 0);
        lit("rst_ns", ns_color, 3'b010);
        lit("rst_ew", ew_color, 3'b100);
        lit("rst_walk", walk, 0);
        lit("rst_ped", ped_pending, 0);
      end
      if (c == 39) lit("idle_phase39", phase, 0);
      @(negedge clk);
    end

    // Car demand cycle
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick = 1'b1; ew_car = 1'b1; ped_req = 1'b0;
      if (c == 7)  lit("car_c7", phase, 0);
      if (c == 8)  lit("car_c8", phase, 1);
      if (c == 11) lit("car_c11", phase, 2);
      if (c == 13) lit("car_c13", phase, 3);
      if (c == 13) lit("car_ew_green", ew_color, 3'b010);
      if (c == 19) lit("car_c19", phase, 4);
      if (c == 22) lit("car_c22", phase, 5);
      if (c == 24) lit("car_c24", phase, 0);
      if (c == 32) lit("car_c32", phase, 1);
      @(negedge clk);
    end

    // Pedestrian only
    do_reset();
    for (int c = 0; c < 25; c++) begin
      tick = 1'b1; ew_car = 1'b0; ped_req = (c == 2);
      if (c == 2)  lit("ped_c2_pend", ped_pending, 0);
      if (c == 3)  lit("ped_c3_pend", ped_pending, 1);
      if (c == 8)  lit("ped_c8", phase, 1);
      if (c == 11) lit("ped_c11", phase, 2);
      if (c == 13) begin
        lit("ped_c13", phase, 6);
        lit("ped_c13_walk", walk, 1);
        lit("ped_c13_ns", ns_color, 3'b100);
        lit("ped_c13_pend", ped_pending, 0);
      end
      if (c == 17) lit("ped_c17", phase, 6);
      if (c == 18) lit("ped_c18", phase, 5);
      if (c == 20) lit("ped_c20", phase, 0);
      @(negedge clk);
    end

    // Car plus pedestrian; presses on the WALK-entry edge and during WALK are dropped
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick = 1'b1; ew_car = 1'b1;
      ped_req = (c == 0 || c == 12 || c == 14 || c == 16);
      if (c == 13) lit("cp_c13", phase, 6);
      if (c == 13) lit("cp_c13_pend", ped_pending, 0);
      if (c == 17) lit("cp_c17_pend", ped_pending, 0);
      if (c == 18) lit("cp_c18", phase, 3);
      if (c == 24) lit("cp_c24", phase, 4);
      if (c == 27) lit("cp_c27", phase, 5);
      if (c == 29) lit("cp_c29", phase, 0);
      @(negedge clk);
    end

    // Tick every 4th clock
    do_reset();
    for (int c = 0; c < 45; c++) begin
      tick = ((c % 4) == 3); ew_car = 1'b1; ped_req = 1'b0;
      if (c == 31) lit("tk_c31", phase, 0);
      if (c == 32) lit("tk_c32", phase, 1);
      if (c == 43) lit("tk_c43", phase, 1);
      if (c == 44) lit("tk_c44", phase, 2);
      @(negedge clk);
    end

    // Reset in the middle of EW_G with a pending request
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick = 1'b1; ew_car = 1'b1; ped_req = (c == 14); rst = (c == 16);
      if (c == 15) begin
        lit("mr_c15", phase, 3);
        lit("mr_c15_pend", ped_pending, 1);
      end
      if (c == 17) begin
        lit("mr_c17", phase, 0);
        lit("mr_c17_ns", ns_color, 3'b010);
        lit("mr_c17_ew", ew_color, 3'b100);
        lit("mr_c17_walk", walk, 0);
        lit("mr_c17_pend", ped_pending, 0);
      end
      @(negedge clk);
    end
    rst = 1'b0;

    // Random soak
    for (int c = 0; c < 10000; c++) begin
      tick    = ($urandom_range(0, 3) != 0);
      ew_car  = ($urandom_range(0, 9) < 3);
      ped_req = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
